// File: rtl/mcp3202_emu_pkg.sv
`timescale 1ns/1ps
// mcp3202_emu_pkg: shared types, widths and cycle-conversion helpers for the
// MCP3202 responder model.
package mcp3202_emu_pkg;

    localparam int unsigned SAMPLE_W = 12;

    // ceil(ns * fclk / 1e9) in 64-bit integer arithmetic
    function automatic int unsigned ns2cyc(input int unsigned ns, input int unsigned fclk);
        longint unsigned prod;
        prod = 64'(ns) * 64'(fclk);
        return 32'((prod + 64'd999_999_999) / 64'd1_000_000_000);
    endfunction

    // Cycle constants at the default 100 MHz fabric clock
    localparam int unsigned TCSH_CYC_DEF    = ns2cyc(500, 100_000_000);
    localparam int unsigned TSUCS_CYC_DEF   = ns2cyc(100, 100_000_000);
    localparam int unsigned SCK_MIN_CYC_DEF = ns2cyc(1112, 100_000_000);
    localparam int unsigned SCK_MAX_CYC_DEF = ns2cyc(100_000, 100_000_000);

    // Counter must hold SCK_MAX+1 at the fastest legal fabric clock
    localparam int unsigned CNT_W = $clog2(ns2cyc(100_000, 200_000_000) + 2);

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_WAIT_START,
        ST_GET_SGL,
        ST_GET_ODD,
        ST_GET_MSBF,
        ST_NULL_BIT,
        ST_TX_MSB,
        ST_TX_LSB,
        ST_ZERO_FILL
    } state_t;

    // Channel / pseudo-differential selection; negative differences clamp to 0
    function automatic logic [SAMPLE_W-1:0] sel_sample(
        input logic                sgl,
        input logic                odd,
        input logic [SAMPLE_W-1:0] ch0,
        input logic [SAMPLE_W-1:0] ch1
    );
        logic [SAMPLE_W:0] diff;
        diff = odd ? ({1'b0, ch1} - {1'b0, ch0}) : ({1'b0, ch0} - {1'b0, ch1});
        if (sgl) begin
            return odd ? ch1 : ch0;
        end
        return diff[SAMPLE_W] ? '0 : diff[SAMPLE_W-1:0];
    endfunction

endpackage

// File: rtl/mcp3202_adc_emulator_sync.sv
`timescale 1ns/1ps
// sync_edge_det: multi-flop synchronizer with one-cycle edge pulses.
//   i_clk, i_rst   fabric clock, synchronous active-high reset
//   i_async        asynchronous input
//   o_level        synchronized level (flop output)
//   o_rise_c       combinational one-cycle rise pulse on o_level
//   o_fall_c       combinational one-cycle fall pulse on o_level
module sync_edge_det #(
    parameter int unsigned DEPTH = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_async,
    output logic o_level,
    output logic o_rise_c,
    output logic o_fall_c
);

    logic [DEPTH-1:0] r_sync;
    logic             r_prev;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[DEPTH-2:0], i_async};
            r_prev <= r_sync[DEPTH-1];
        end
    end

    assign o_level  = r_sync[DEPTH-1];
    assign o_rise_c = r_sync[DEPTH-1] & ~r_prev;
    assign o_fall_c = ~r_sync[DEPTH-1] & r_prev;

endmodule

// File: rtl/mcp3202_adc_emulator.sv
`timescale 1ns/1ps
// mcp3202_adc_emulator: MCP3202 SPI ADC responder for hardware-in-loop tests.
//   i_clk, i_rst                fabric clock, synchronous active-high reset
//   i_cs, i_sck, i_mosi         asynchronous SPI inputs (cs active low)
//   o_miso, o_miso_oe           DOUT and its output enable
//   i_ch0_sample, i_ch1_sample  12-bit channel values
//   o_cfg_valid/sgl/odd/msbf    captured configuration (valid pulses on MSBF)
//   o_xfer_done                 pulse on cs rise after a complete MSB-first word
//   o_err_*, i_err_clr          sticky timing-violation flags and their clear
module mcp3202_adc_emulator
    import mcp3202_emu_pkg::*;
#(
    parameter int unsigned FCLK         = 100_000_000,
    parameter int unsigned SYNC_STAGES  = 2,
    parameter int unsigned TCSH_MIN_NS  = 500,
    parameter int unsigned TSUCS_MIN_NS = 100,
    parameter int unsigned SCK_MIN_NS   = 1112,
    parameter int unsigned SCK_MAX_NS   = 100_000
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_cs,
    input  logic                i_sck,
    input  logic                i_mosi,
    output logic                o_miso,
    output logic                o_miso_oe,
    input  logic [SAMPLE_W-1:0] i_ch0_sample,
    input  logic [SAMPLE_W-1:0] i_ch1_sample,
    output logic                o_cfg_valid,
    output logic                o_cfg_sgl,
    output logic                o_cfg_odd,
    output logic                o_cfg_msbf,
    output logic                o_xfer_done,
    output logic                o_err_tcsh,
    output logic                o_err_tsucs,
    output logic                o_err_sck_fast,
    output logic                o_err_sck_slow,
    input  logic                i_err_clr
);

    localparam logic [CNT_W-1:0] K_TCSH    = CNT_W'(ns2cyc(TCSH_MIN_NS, FCLK));
    localparam logic [CNT_W-1:0] K_TSUCS   = CNT_W'(ns2cyc(TSUCS_MIN_NS, FCLK));
    localparam logic [CNT_W-1:0] K_SCK_MIN = CNT_W'(ns2cyc(SCK_MIN_NS, FCLK));
    localparam logic [CNT_W-1:0] K_SCK_MAX = CNT_W'(ns2cyc(SCK_MAX_NS, FCLK));
    localparam logic [3:0]       K_IDX_TOP = 4'(SAMPLE_W - 1);

    logic w_cs, w_cs_rise, w_cs_fall;
    logic w_unused_sck, w_sck_rise, w_sck_fall;
    logic w_mosi, w_unused_mosi_rise, w_unused_mosi_fall;

    sync_edge_det #(.DEPTH(SYNC_STAGES)) u_sync_cs (
        .i_clk(i_clk), .i_rst(i_rst), .i_async(i_cs),
        .o_level(w_cs), .o_rise_c(w_cs_rise), .o_fall_c(w_cs_fall)
    );
    sync_edge_det #(.DEPTH(SYNC_STAGES)) u_sync_sck (
        .i_clk(i_clk), .i_rst(i_rst), .i_async(i_sck),
        .o_level(w_unused_sck), .o_rise_c(w_sck_rise), .o_fall_c(w_sck_fall)
    );
    sync_edge_det #(.DEPTH(SYNC_STAGES)) u_sync_mosi (
        .i_clk(i_clk), .i_rst(i_rst), .i_async(i_mosi),
        .o_level(w_mosi), .o_rise_c(w_unused_mosi_rise), .o_fall_c(w_unused_mosi_fall)
    );

    state_t              r_state, w_state_nx;
    logic [3:0]          r_idx, w_idx_nx;
    logic [SAMPLE_W-1:0] r_word, w_word_nx;
    logic                r_miso, w_miso_nx, r_oe, w_oe_nx;
    logic                r_sgl, w_sgl_nx, r_odd, w_odd_nx, r_msbf, w_msbf_nx;
    logic                r_cfg_valid, w_cfg_valid_nx, r_xfer_done, w_xfer_done_nx;
    logic [CNT_W-1:0]    r_tcsh_cnt, r_sck_cnt;
    logic                r_seen_rise;
    logic                r_err_tcsh, r_err_tsucs, r_err_fast, r_err_slow;

    // sck edges only count while a frame is open (cs low and out of IDLE)
    logic w_active, w_rise_g, w_fall_g;
    assign w_active = ~w_cs & (r_state != ST_IDLE);
    assign w_rise_g = w_sck_rise & w_active;
    assign w_fall_g = w_sck_fall & w_active;

    // cs-high time, saturating at the minimum
    always_ff @(posedge i_clk) begin
        if (i_rst || w_cs_rise) begin
            r_tcsh_cnt <= '0;
        end else if (r_state == ST_IDLE && w_cs && r_tcsh_cnt < K_TCSH) begin
            r_tcsh_cnt <= r_tcsh_cnt + CNT_W'(1);
        end
    end

    // Shared counter: cs fall to first rise, then rise-to-rise; reads N after N cycles
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sck_cnt   <= '0;
            r_seen_rise <= 1'b0;
        end else if (w_cs_fall) begin
            r_sck_cnt   <= CNT_W'(1);
            r_seen_rise <= 1'b0;
        end else if (w_rise_g) begin
            r_sck_cnt   <= CNT_W'(1);
            r_seen_rise <= 1'b1;
        end else if (w_active && r_sck_cnt <= K_SCK_MAX) begin
            r_sck_cnt <= r_sck_cnt + CNT_W'(1);
        end
    end

    logic w_tcsh_viol, w_tsucs_viol, w_fast_viol, w_slow_viol;
    assign w_tcsh_viol  = (r_state == ST_IDLE) & w_cs_fall & (r_tcsh_cnt < K_TCSH);
    assign w_tsucs_viol = w_rise_g & ~r_seen_rise & (r_sck_cnt < K_TSUCS);
    assign w_fast_viol  = w_rise_g & r_seen_rise & (r_sck_cnt < K_SCK_MIN);
    assign w_slow_viol  = w_active & r_seen_rise & (r_sck_cnt > K_SCK_MAX);

    // Sticky flags; a same-cycle violation beats the clear
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_err_tcsh  <= 1'b0;
            r_err_tsucs <= 1'b0;
            r_err_fast  <= 1'b0;
            r_err_slow  <= 1'b0;
        end else begin
            r_err_tcsh  <= (r_err_tcsh  & ~i_err_clr) | w_tcsh_viol;
            r_err_tsucs <= (r_err_tsucs & ~i_err_clr) | w_tsucs_viol;
            r_err_fast  <= (r_err_fast  & ~i_err_clr) | w_fast_viol;
            r_err_slow  <= (r_err_slow  & ~i_err_clr) | w_slow_viol;
        end
    end

    // Frame FSM state and registered outputs
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= ST_IDLE;
            r_idx       <= '0;
            r_word      <= '0;
            r_miso      <= 1'b0;
            r_oe        <= 1'b0;
            r_sgl       <= 1'b0;
            r_odd       <= 1'b0;
            r_msbf      <= 1'b0;
            r_cfg_valid <= 1'b0;
            r_xfer_done <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_idx       <= w_idx_nx;
            r_word      <= w_word_nx;
            r_miso      <= w_miso_nx;
            r_oe        <= w_oe_nx;
            r_sgl       <= w_sgl_nx;
            r_odd       <= w_odd_nx;
            r_msbf      <= w_msbf_nx;
            r_cfg_valid <= w_cfg_valid_nx;
            r_xfer_done <= w_xfer_done_nx;
        end
    end

    // Next-state: decode on sck rise, shift on sck fall, cs rise ends any frame
    always_comb begin
        w_state_nx      = r_state;
        w_idx_nx        = r_idx;
        w_word_nx       = r_word;
        w_miso_nx       = r_miso;
        w_oe_nx         = r_oe;
        w_sgl_nx        = r_sgl;
        w_odd_nx        = r_odd;
        w_msbf_nx       = r_msbf;
        w_cfg_valid_nx  = 1'b0;
        w_xfer_done_nx  = 1'b0;
        if (w_cs_rise) begin
            w_state_nx     = ST_IDLE;
            w_oe_nx        = 1'b0;
            w_miso_nx      = 1'b0;
            w_xfer_done_nx = (r_state == ST_TX_LSB) || (r_state == ST_ZERO_FILL);
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_cs_fall) w_state_nx = ST_WAIT_START;
                end
                ST_WAIT_START: begin
                    if (w_rise_g && w_mosi) w_state_nx = ST_GET_SGL;
                end
                ST_GET_SGL: begin
                    if (w_rise_g) begin
                        w_sgl_nx   = w_mosi;
                        w_state_nx = ST_GET_ODD;
                    end
                end
                ST_GET_ODD: begin
                    if (w_rise_g) begin
                        w_odd_nx   = w_mosi;
                        w_state_nx = ST_GET_MSBF;
                    end
                end
                ST_GET_MSBF: begin
                    if (w_rise_g) begin
                        w_msbf_nx      = w_mosi;
                        w_cfg_valid_nx = 1'b1;
                        w_word_nx      = sel_sample(r_sgl, r_odd, i_ch0_sample, i_ch1_sample);
                        w_state_nx     = ST_NULL_BIT;
                    end
                end
                ST_NULL_BIT: begin
                    if (w_fall_g) begin
                        w_oe_nx    = 1'b1;
                        w_miso_nx  = 1'b0;
                        w_idx_nx   = K_IDX_TOP;
                        w_state_nx = ST_TX_MSB;
                    end
                end
                ST_TX_MSB: begin
                    if (w_fall_g) begin
                        w_miso_nx = r_word[r_idx];
                        if (r_idx == 4'd0) begin
                            if (r_msbf) begin
                                w_state_nx = ST_ZERO_FILL;
                            end else begin
                                w_idx_nx   = 4'd1;
                                w_state_nx = ST_TX_LSB;
                            end
                        end else begin
                            w_idx_nx = r_idx - 4'd1;
                        end
                    end
                end
                ST_TX_LSB: begin
                    if (w_fall_g) begin
                        w_miso_nx = r_word[r_idx];
                        if (r_idx == K_IDX_TOP) w_state_nx = ST_ZERO_FILL;
                        else                    w_idx_nx   = r_idx + 4'd1;
                    end
                end
                ST_ZERO_FILL: begin
                    if (w_fall_g) w_miso_nx = 1'b0;
                end
                default: w_state_nx = ST_IDLE;
            endcase
        end
    end

    assign o_miso         = r_miso;
    assign o_miso_oe      = r_oe;
    assign o_cfg_valid    = r_cfg_valid;
    assign o_cfg_sgl      = r_sgl;
    assign o_cfg_odd      = r_odd;
    assign o_cfg_msbf     = r_msbf;
    assign o_xfer_done    = r_xfer_done;
    assign o_err_tcsh     = r_err_tcsh;
    assign o_err_tsucs    = r_err_tsucs;
    assign o_err_sck_fast = r_err_fast;
    assign o_err_sck_slow = r_err_slow;

endmodule
